// File: rtl/ov7670_cfg_seq.sv
`default_nettype none
// ============================================================================
//  Module      : ov7670_cfg_seq
//  Description : Walks the OV7670 register ROM and issues one SCCB write per
//                word, with a settle delay after a COM7 soft reset and NACK retry.
//  Revision    : 1.0  initial release
// ============================================================================
module ov7670_cfg_seq #(
    parameter int ADDR_W       = 6,
    parameter int NUM_REGS     = 59,
    parameter int RST_WAIT_CYC = 100000,
    parameter int RETRY_MAX    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_cfg,
    output logic [ADDR_W-1:0] cnt_reg,
    input  logic [15:0]       reg_data,
    output logic              sccb_start,
    output logic [7:0]        sccb_addr,
    output logic [7:0]        sccb_data,
    input  logic              sccb_done,
    input  logic              sccb_nack,
    output logic              busy,
    output logic              cfg_done,
    output logic              cfg_err
);

    localparam int c_DLY_W = $clog2(RST_WAIT_CYC + 1);
    localparam int c_RTY_W = $clog2(RETRY_MAX + 1);

    localparam logic [ADDR_W-1:0]  c_CNT_LAST = ADDR_W'(NUM_REGS);
    localparam logic [c_RTY_W-1:0] c_RTY_MAX  = c_RTY_W'(RETRY_MAX);
    localparam logic [c_DLY_W-1:0] c_DLY_LOAD = c_DLY_W'(RST_WAIT_CYC - 1);
    localparam logic [15:0]        c_FINISH_WORD = 16'hFFFF;
    localparam logic [7:0]         c_COM7_ADDR   = 8'h12;

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_FETCH  = 3'd1;
    localparam logic [2:0] c_ST_SEND   = 3'd2;
    localparam logic [2:0] c_ST_WAIT   = 3'd3;
    localparam logic [2:0] c_ST_DELAY  = 3'd4;
    localparam logic [2:0] c_ST_FINISH = 3'd5;
    localparam logic [2:0] c_ST_ERROR  = 3'd6;

    logic [2:0]         r_state,  w_state_nxt;
    logic [ADDR_W-1:0]  r_cnt,    w_cnt_nxt;
    logic [7:0]         r_addr,   w_addr_nxt;
    logic [7:0]         r_data,   w_data_nxt;
    logic [c_RTY_W-1:0] r_retry,  w_retry_nxt;
    logic [c_RTY_W-1:0] w_retry_inc;
    logic [c_DLY_W-1:0] r_dly,    w_dly_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_retry <= '0;
            r_dly   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_addr  <= w_addr_nxt;
            r_data  <= w_data_nxt;
            r_retry <= w_retry_nxt;
            r_dly   <= w_dly_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_retry_nxt = r_retry;
        w_dly_nxt   = r_dly;
        w_retry_inc = r_retry + c_RTY_W'(1);

        case (r_state)
            c_ST_IDLE, c_ST_FINISH, c_ST_ERROR: begin
                if (start_cfg) begin
                    w_cnt_nxt   = '0;
                    w_retry_nxt = '0;
                    w_state_nxt = c_ST_FETCH;
                end
            end
            c_ST_FETCH: begin
                // The index bound terminates a ROM that lacks its finish word
                if (reg_data == c_FINISH_WORD || r_cnt == c_CNT_LAST) begin
                    w_state_nxt = c_ST_FINISH;
                end else begin
                    w_addr_nxt  = reg_data[15:8];
                    w_data_nxt  = reg_data[7:0];
                    w_state_nxt = c_ST_SEND;
                end
            end
            c_ST_SEND: begin
                w_state_nxt = c_ST_WAIT;
            end
            c_ST_WAIT: begin
                if (sccb_done) begin
                    if (sccb_nack) begin
                        w_retry_nxt = w_retry_inc;
                        w_state_nxt = (w_retry_inc < c_RTY_MAX) ? c_ST_SEND : c_ST_ERROR;
                    end else begin
                        w_retry_nxt = '0;
                        // COM7 soft reset needs the sensor to settle before the next write
                        if (r_addr == c_COM7_ADDR && r_data[7]) begin
                            w_dly_nxt   = c_DLY_LOAD;
                            w_state_nxt = c_ST_DELAY;
                        end else begin
                            w_cnt_nxt   = r_cnt + ADDR_W'(1);
                            w_state_nxt = c_ST_FETCH;
                        end
                    end
                end
            end
            c_ST_DELAY: begin
                if (r_dly == '0) begin
                    w_cnt_nxt   = r_cnt + ADDR_W'(1);
                    w_state_nxt = c_ST_FETCH;
                end else begin
                    w_dly_nxt = r_dly - c_DLY_W'(1);
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    assign cnt_reg    = r_cnt;
    assign sccb_addr  = r_addr;
    assign sccb_data  = r_data;
    assign sccb_start = (r_state == c_ST_SEND);
    assign busy       = (r_state == c_ST_FETCH) || (r_state == c_ST_SEND) ||
                        (r_state == c_ST_WAIT)  || (r_state == c_ST_DELAY);
    assign cfg_done   = (r_state == c_ST_FINISH);
    assign cfg_err    = (r_state == c_ST_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_ov7670_cfg_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ov7670_cfg_seq
//  Description : Scoreboard bench for ov7670_cfg_seq with ROM and SCCB master models.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ov7670_cfg_seq;

    localparam int RST_WAIT  = 20;
    localparam int NUM_REGS  = 59;
    localparam int RETRY_MAX = 3;

    localparam logic [15:0] TBL [0:56] = '{
        16'h1280, 16'h1204, 16'h1100, 16'h40F0, 16'h8C02, 16'h0C00, 16'h3E00, 16'h0400,
        16'h3A04, 16'h1438, 16'h4FB3, 16'h50B3, 16'h5100, 16'h523D, 16'h53A7, 16'h54E4,
        16'h589E, 16'h3DC0, 16'h1711, 16'h1861, 16'h32A4, 16'h1903, 16'h1A7B, 16'h030A,
        16'h0E61, 16'h0F4B, 16'h1602, 16'h1E37, 16'h2102, 16'h2291, 16'h2907, 16'h330B,
        16'h350B, 16'h371D, 16'h3871, 16'h392A, 16'h3C78, 16'h4D40, 16'h4E20, 16'h6900,
        16'h6B4A, 16'h7410, 16'h8D4F, 16'h8E00, 16'h8F00, 16'h9000, 16'h9100, 16'h9600,
        16'h9A00, 16'hB084, 16'hB10C, 16'hB20E, 16'hB382, 16'hB80A, 16'h13E7, 16'hAA94,
        16'hA202
    };

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
        logic [5:0] idx;
        int         gap;
    } item_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_main = 1'b0;
    logic        start_noise = 1'b0;
    logic        start_cfg;
    logic [5:0]  cnt_reg;
    logic [15:0] reg_data;
    logic        sccb_start;
    logic [7:0]  sccb_addr;
    logic [7:0]  sccb_data;
    logic        sccb_done = 1'b0;
    logic        sccb_nack = 1'b0;
    logic        busy;
    logic        cfg_done;
    logic        cfg_err;

    int    n_cmp = 0;
    int    n_err = 0;
    int    cyc = 0;
    int    stim_evt_cyc = 0;
    int    done_evt_cyc = 0;
    int    run_id = 0;
    int    lat_fixed = 10;
    bit    noise_en = 1'b0;
    bit    stray_en = 1'b0;
    bit    term_mode = 1'b1;
    int    nack_plan [64];
    item_t exp_q [$];
    bit    exp_err;
    int    exp_idx;

    assign start_cfg = start_main | start_noise;

    ov7670_cfg_seq #(
        .ADDR_W       (6),
        .NUM_REGS     (NUM_REGS),
        .RST_WAIT_CYC (RST_WAIT),
        .RETRY_MAX    (RETRY_MAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_cfg  (start_cfg),
        .cnt_reg    (cnt_reg),
        .reg_data   (reg_data),
        .sccb_start (sccb_start),
        .sccb_addr  (sccb_addr),
        .sccb_data  (sccb_data),
        .sccb_done  (sccb_done),
        .sccb_nack  (sccb_nack),
        .busy       (busy),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ROM contents; without the terminator the index bound must end the walk
    function automatic logic [15:0] rom_word(input int idx, input bit term);
        if (!term && idx == 57) return 16'h3D88;
        if (idx < 57)  return TBL[idx];
        if (idx == 57) return 16'hFFFF;
        if (idx == 58) return 16'h1E07;
        if (idx == 59) return 16'h2A00;
        return 16'h0000;
    endfunction

    always_comb reg_data = rom_word(int'(cnt_reg), term_mode);

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Transaction-level expectation: every write attempt in order, with the
    // cycle distance from the event that triggers it (start_cfg or sccb_done).
    task automatic plan_run(input int stop_idx);
        int          idx;
        int          gap;
        int          n_att;
        logic [15:0] w;
        item_t       it;
        idx     = 0;
        gap     = 2;
        exp_err = 1'b0;
        while (idx < NUM_REGS) begin
            w = rom_word(idx, term_mode);
            if (w == 16'hFFFF) break;
            n_att = (nack_plan[idx] >= RETRY_MAX) ? RETRY_MAX : nack_plan[idx] + 1;
            for (int a = 0; a < n_att; a++) begin
                it.addr = w[15:8];
                it.data = w[7:0];
                it.idx  = 6'(idx);
                it.gap  = gap;
                exp_q.push_back(it);
                gap = 1;
            end
            if (idx == stop_idx) break;
            if (nack_plan[idx] >= RETRY_MAX) begin
                exp_err = 1'b1;
                break;
            end
            gap = (w[15:8] == 8'h12 && w[7]) ? RST_WAIT + 2 : 2;
            idx++;
        end
        exp_idx = idx;
    endtask

    // SCCB master model
    initial begin
        int done_cd;
        int stray_cd;
        int seen_run;
        int att_cnt [64];
        int i;
        bit cur_nk;
        bit cur_rst;
        done_cd  = 0;
        stray_cd = 0;
        seen_run = -1;
        cur_nk   = 1'b0;
        cur_rst  = 1'b0;
        forever begin
            @(negedge clk);
            sccb_done = 1'b0;
            sccb_nack = 1'b0;
            if (seen_run != run_id) begin
                foreach (att_cnt[k]) att_cnt[k] = 0;
                seen_run = run_id;
            end
            if (done_cd > 0) begin
                done_cd--;
                if (done_cd == 0) begin
                    sccb_done    = 1'b1;
                    sccb_nack    = cur_nk;
                    done_evt_cyc = cyc;
                    if (stray_en && !cur_nk)
                        stray_cd = cur_rst ? int'($urandom_range(1, RST_WAIT + 1)) : 1;
                end
            end else if (stray_cd > 0) begin
                stray_cd--;
                if (stray_cd == 0) begin
                    sccb_done = 1'b1;
                    sccb_nack = 1'($urandom_range(0, 1));
                end
            end
            if (sccb_start) begin
                i = int'(cnt_reg);
                cur_nk  = (att_cnt[i] < nack_plan[i]);
                att_cnt[i]++;
                cur_rst = (sccb_addr == 8'h12) && sccb_data[7];
                done_cd = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 11));
            end
        end
    end

    // Restart attempts while busy; busy seen here is the state at the sampling edge
    initial begin
        forever begin
            @(negedge clk);
            start_noise = noise_en && busy && ($urandom_range(0, 5) == 0);
        end
    end

    // Scoreboard monitor
    initial begin
        item_t it;
        int    ref_cyc;
        forever begin
            @(negedge clk);
            if (sccb_start) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_sccb_start: got addr %0h data %0h idx %0h, expected none (t=%0t)",
                             sccb_addr, sccb_data, cnt_reg, $time);
                end else begin
                    it      = exp_q.pop_front();
                    ref_cyc = (stim_evt_cyc > done_evt_cyc) ? stim_evt_cyc : done_evt_cyc;
                    chk("sccb_addr",  int'(sccb_addr), int'(it.addr));
                    chk("sccb_data",  int'(sccb_data), int'(it.data));
                    chk("word_index", int'(cnt_reg),   int'(it.idx));
                    chk("start_gap",  cyc - ref_cyc,   it.gap);
                end
            end
        end
    end

    task automatic kick(input int stop_idx);
        plan_run(stop_idx);
        run_id++;
        @(negedge clk);
        start_main   = 1'b1;
        stim_evt_cyc = cyc;
        @(negedge clk);
        start_main = 1'b0;
        chk("busy_after_start",   int'(busy),     1);
        chk("cfg_done_on_start",  int'(cfg_done), 0);
        chk("cfg_err_on_start",   int'(cfg_err),  0);
    endtask

    task automatic do_run();
        int k;
        kick(-1);
        for (k = 0; k < 6000; k++) begin
            if (!busy) break;
            @(negedge clk);
        end
        chk("run_terminates",  int'(busy),     0);
        chk("cfg_done_final",  int'(cfg_done), int'(!exp_err));
        chk("cfg_err_final",   int'(cfg_err),  int'(exp_err));
        chk("final_index",     int'(cnt_reg),  exp_idx);
        chk("words_remaining", exp_q.size(),   0);
        exp_q.delete();
        repeat (25) @(negedge clk);
        chk("result_held",     int'(cfg_done | cfg_err), 1);
        chk("index_held",      int'(cnt_reg),  exp_idx);
    endtask

    initial begin
        int  k;
        int  r;
        bit  hit;
        foreach (nack_plan[j]) nack_plan[j] = 0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy",  int'(busy),       0);
        chk("rst_done",  int'(cfg_done),   0);
        chk("rst_err",   int'(cfg_err),    0);
        chk("rst_start", int'(sccb_start), 0);
        chk("rst_cnt",   int'(cnt_reg),    0);
        chk("rst_addr",  int'(sccb_addr),  0);
        chk("rst_data",  int'(sccb_data),  0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_without_start", int'(busy), 0);

        // Clean full run with fixed master latency
        lat_fixed = 10;
        do_run();

        // Two NACKs on index 3, then ACK
        lat_fixed    = 0;
        nack_plan[3] = 2;
        do_run();

        // Retries exhausted on index 3, then restart from ERROR
        nack_plan[3] = 3;
        do_run();
        nack_plan[3] = 0;
        do_run();

        // Asynchronous reset during WAIT_DONE of index 10
        lat_fixed = 10;
        kick(10);
        hit = 1'b0;
        for (k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (sccb_start && cnt_reg == 6'd10) begin
                hit = 1'b1;
                break;
            end
        end
        chk("reached_index10", int'(hit), 1);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("async_busy",  int'(busy),       0);
        chk("async_start", int'(sccb_start), 0);
        chk("async_cnt",   int'(cnt_reg),    0);
        chk("async_addr",  int'(sccb_addr),  0);
        chk("async_data",  int'(sccb_data),  0);
        chk("async_flags", int'(cfg_done | cfg_err), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("post_reset_idle",  int'(busy),    0);
        chk("post_reset_cnt",   int'(cnt_reg), 0);
        chk("post_reset_queue", exp_q.size(),  0);
        exp_q.delete();

        // Randomised NACKs with restart noise and stray done pulses
        lat_fixed = 0;
        noise_en  = 1'b1;
        stray_en  = 1'b1;
        for (int run = 0; run < 3; run++) begin
            foreach (nack_plan[j]) begin
                r = int'($urandom_range(0, 99));
                nack_plan[j] = (r < 8) ? int'($urandom_range(1, 2)) : ((r < 9) ? 3 : 0);
            end
            do_run();
        end
        noise_en = 1'b0;
        stray_en = 1'b0;
        foreach (nack_plan[j]) nack_plan[j] = 0;

        // ROM without a finish word: index bound ends the walk
        term_mode = 1'b0;
        do_run();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
